// File: rtl/data_mem_mmio_if.sv
// Data-side bus between the single-cycle core and data_mem_mmio.
//   Address    word address (ALU result)
//   WriteData  store data
//   MemWrite   store strobe, sampled at the clock edge
//   MemRead    load enable
//   ReadData   combinational load data back to the core
interface data_mem_mmio_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;

  modport master (output Address, output WriteData, output MemWrite,
                  output MemRead, input ReadData);
  modport slave  (input Address, input WriteData, input MemWrite,
                  input MemRead, output ReadData);
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory for the single-cycle MIPS-32 core with a small MMIO window.
//   Address[31]=0 : word RAM of 2**ADDR_W entries, index Address[ADDR_W-1:0]
//   Address[31]=1 : register selected by Address[1:0]
//     0 TXDATA  W: push byte to UART TX FIFO, R: 0
//     1 STATUS  R: [0]full [1]empty [2]busy [3]ovf [7:4]count, W: clear ovf
//     2 CYCLE   R: free-running cycle counter, W: clear
//     3         reads 0, writes ignored
// Ports:
//   Clock   system clock, all state on posedge
//   Reset   asynchronous, active-high
//   bus     slave side of data_mem_mmio_if (Address/WriteData/MemWrite/MemRead/ReadData)
//   UartTx  8N1 serial output, LSB first, idle high
module data_mem_mmio #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic             Clock,
  input  logic             Reset,
  data_mem_mmio_if.slave   bus,
  output logic             UartTx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [31:0]       ram  [(1 << ADDR_W)];
  logic [7:0]        fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [31:0]       cycle;
  tx_state_t         state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  logic        is_mmio;
  logic [1:0]  reg_sel;
  logic        push_req, push_ok, pop, status_wr, cycle_wr;
  logic        full, empty, busy;
  logic [31:0] status;
  logic        unused_addr;

  assign is_mmio     = bus.Address[31];
  assign reg_sel     = bus.Address[1:0];
  assign unused_addr = ^bus.Address;

  assign push_req  = bus.MemWrite && is_mmio && (reg_sel == 2'd0);
  assign status_wr = bus.MemWrite && is_mmio && (reg_sel == 2'd1);
  assign cycle_wr  = bus.MemWrite && is_mmio && (reg_sel == 2'd2);

  assign pop     = (state == IDLE) && (count != '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_req && ((count < DEPTH_C) || pop);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = busy;
    status[3]   = ovf;
    status[7:4] = 4'(count);
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead) begin
      if (!is_mmio) begin
        bus.ReadData = ram[bus.Address[ADDR_W-1:0]];
      end else begin
        unique case (reg_sel)
          2'd1:    bus.ReadData = status;
          2'd2:    bus.ReadData = cycle;
          default: bus.ReadData = '0;
        endcase
      end
    end
  end

  // RAM contents survive Reset.
  always_ff @(posedge Clock) begin
    if (bus.MemWrite && !is_mmio) begin
      ram[bus.Address[ADDR_W-1:0]] <= bus.WriteData;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      fifo[wr_ptr] <= bus.WriteData[7:0];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      // Setting on a dropped byte takes priority over a clear in the same cycle.
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (status_wr)       ovf <= 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         cycle <= '0;
    else if (cycle_wr) cycle <= '0;
    else               cycle <= cycle + 32'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      UartTx  <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          UartTx <= 1'b1;
          baud   <= '0;
          if (pop) begin
            shreg  <= fifo[rd_ptr];
            UartTx <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            UartTx  <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              UartTx <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              UartTx  <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed testbench for data_mem_mmio (ADDR_W=8, FIFO_DEPTH=8, CLKS_PER_BIT=4).
module tb_data_mem_mmio;

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0001;
  localparam logic [31:0] CYCLE  = 32'h8000_0002;
  localparam logic [31:0] NOREG  = 32'h8000_0003;

  logic Clock;
  logic Reset;
  logic UartTx;
  int unsigned vectors;
  int unsigned miscompares;

  data_mem_mmio_if bus ();

  data_mem_mmio #(.ADDR_W(8), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .bus    (bus),
    .UartTx (UartTx)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clock);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    @(negedge Clock);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge Clock);
    bus.Address  = a;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    #1 d = bus.ReadData;
  endtask

  // Returns at the negedge (+1) where the transmitter is seen idle.
  task automatic wait_idle();
    int unsigned n;
    n = 0;
    @(negedge Clock);
    bus.Address  = STATUS;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    #1;
    while (bus.ReadData[2] !== 1'b0 && n < 300) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check("idle_timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Samples every negedge: each of the 10 bit slots must be 4 identical samples.
  task automatic uart_rx(output logic [7:0] b);
    int unsigned n;
    logic [9:0] f;
    logic bad;
    n = 0;
    bad = 1'b0;
    @(negedge Clock);
    bus.Address  = STATUS;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    while (UartTx !== 1'b0 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check("rx_start_timeout", (n >= 300) ? 32'd1 : 32'd0, 32'd0);
    for (int s = 0; s < 10; s++) begin
      f[s] = UartTx;
      for (int k = 1; k < 4; k++) begin
        @(negedge Clock);
        if (UartTx !== f[s]) bad = 1'b1;
      end
      if (s == 4) check("busy_mid_frame", {31'b0, bus.ReadData[2]}, 32'd1);
      if (s < 9) @(negedge Clock);
    end
    check("bit_width", {31'b0, bad}, 32'd0);
    check("start_bit", {31'b0, f[0]}, 32'd0);
    check("stop_bit", {31'b0, f[9]}, 32'd1);
    b = f[8:1];
  endtask

  initial begin
    logic [31:0] d, a0, a1;
    logic [7:0]  b;
    int unsigned lows;
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    bus.Address = '0;
    bus.WriteData = '0;
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;

    // Reset state
    repeat (3) @(negedge Clock);
    check("reset_tx", {31'b0, UartTx}, 32'd1);
    bus.MemRead = 1'b1;
    bus.Address = STATUS;
    #1 check("reset_status", bus.ReadData, 32'h02);
    bus.Address = CYCLE;
    #1 check("reset_cycle", bus.ReadData, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // RAM, aliasing and read gating
    wr(32'd5, 32'hDEAD_BEEF);
    rd(32'd5, d);     check("ram_read", d, 32'hDEAD_BEEF);
    rd(32'h105, d);   check("ram_alias", d, 32'hDEAD_BEEF);
    @(negedge Clock);
    bus.MemRead = 1'b0;
    bus.Address = 32'd5;
    #1 check("read_gated", bus.ReadData, 32'd0);
    wr(32'd7, 32'h1111_1111);
    @(negedge Clock);
    bus.Address = 32'd7;
    bus.WriteData = 32'h2222_2222;
    bus.MemWrite = 1'b1;
    bus.MemRead = 1'b1;
    #1 check("rw_same_cycle_pre", bus.ReadData, 32'h1111_1111);
    @(negedge Clock);
    bus.MemWrite = 1'b0;
    #1 check("rw_same_cycle_post", bus.ReadData, 32'h2222_2222);
    wr(NOREG, 32'hFFFF_FFFF);
    rd(NOREG, d);     check("reg3_read", d, 32'd0);
    rd(TXDATA, d);    check("txdata_read", d, 32'd0);

    // Cycle counter
    @(negedge Clock);
    bus.Address = CYCLE;
    bus.MemRead = 1'b1;
    #1 a0 = bus.ReadData;
    repeat (3) @(negedge Clock);
    #1 a1 = bus.ReadData;
    check("cycle_delta", a1 - a0, 32'd3);
    wr(CYCLE, 32'h1234_5678);
    bus.Address = CYCLE;
    bus.MemRead = 1'b1;
    #1 check("cycle_clear", bus.ReadData, 32'd0);
    @(negedge Clock);
    force dut.cycle = 32'hFFFF_FFFF;
    #1 release dut.cycle;
    #1 check("cycle_preload", bus.ReadData, 32'hFFFF_FFFF);
    @(negedge Clock);
    #1 check("cycle_wrap", bus.ReadData, 32'd0);

    // Single frame
    wr(TXDATA, 32'h55);
    uart_rx(b);
    check("frame_55", {24'b0, b}, 32'h55);
    rd(STATUS, d);    check("status_after_frame", d, 32'h02);

    // Overflow: TX busy with a dummy byte while 10 bytes are pushed
    wr(TXDATA, 32'h00);
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 10; i++) wr(TXDATA, 32'h41 + i);
    rd(STATUS, d);    check("status_overflow", d, 32'h8D);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      uart_rx(b);
      check("fifo_order", {24'b0, b}, 32'h41 + i);
    end
    rd(STATUS, d);    check("ovf_sticky", d, 32'h0A);
    wr(STATUS, 32'h0);
    rd(STATUS, d);    check("ovf_cleared", d, 32'h02);

    // Push into a full FIFO on the edge the transmitter pops
    wr(TXDATA, 32'h00);
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 8; i++) wr(TXDATA, 32'h61 + i);
    rd(STATUS, d);    check("status_full", d, 32'h85);
    wait_idle();
    bus.Address = TXDATA;
    bus.WriteData = 32'h5A;
    bus.MemWrite = 1'b1;
    bus.MemRead = 1'b0;
    @(negedge Clock);
    bus.MemWrite = 1'b0;
    rd(STATUS, d);    check("push_on_pop_status", d, 32'h85);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      uart_rx(b);
      check("push_on_pop_order", {24'b0, b}, (i < 7) ? 32'h62 + i : 32'h5A);
    end
    rd(STATUS, d);    check("drained", d, 32'h02);

    // Reset in the middle of a data bit (bit1 of 0xA5 is 0)
    wr(TXDATA, 32'hA5);
    repeat (10) @(negedge Clock);
    bus.Address = STATUS;
    bus.MemRead = 1'b1;
    #1 check("busy_before_reset", {31'b0, bus.ReadData[2]}, 32'd1);
    check("tx_mid_bit", {31'b0, UartTx}, 32'd0);
    #1 Reset = 1'b1;
    #1 check("reset_tx_immediate", {31'b0, UartTx}, 32'd1);
    check("reset_status_mid", bus.ReadData, 32'h02);
    bus.Address = CYCLE;
    #1 check("reset_cycle_mid", bus.ReadData, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (UartTx !== 1'b1) lows++;
    end
    check("no_spurious_frame", lows, 32'd0);
    rd(STATUS, d);    check("status_post_reset", d, 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
